module_uart_rx_periph: RTL and testbench
========================================

# module_uart_rx_periph

Memory-mapped UART receiver peripheral for the multicycle processor's external bus. It is the receive counterpart of the existing UART transmitter. It samples the serial `rx_i` line as 8N1 and queues received bytes in a small FIFO. It exposes status and data registers through the same `we_i`/address/data convention used by the other peripherals behind the bus conductor.

## Interface
- `CLK_HZ`, default 10_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate. `DIV = CLK_HZ/BAUD` (integer division) is the clocks per bit; `DIV` ≥ 4 is required.
- `FIFO_DEPTH`, default 4: receive FIFO entries; must be a power of two.

Ports:
- `clk_i` in 1: system clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `we_i` in 1: write strobe from the bus conductor, qualified for this peripheral.
- `addr_i` in 2: register select, driven from bus `adr[3:2]`.
- `data_i` in 32: write data.
- `rx_i` in 1: serial input, asynchronous, idle high.
- `data_o` in/out: out, 32 bits: read data, combinational from `addr_i`.
- `rx_valid_o` out 1: high while the FIFO is not empty.

## Operation
Register map:
- `addr_i = 0`, STATUS.
  - Read: bit0 = valid (FIFO not empty), bit1 = overrun, bit2 = frame error, bits[6:4] = FIFO count, all other bits 0.
  - Write: `data_i[0]=1` pops the FIFO head. `data_i[1]=1` clears overrun. `data_i[2]=1` clears frame error.
- `addr_i = 1`, DATA.
  - Read: `{24'b0, head byte}`. Reads 0 when the FIFO is empty.
  - Writes are ignored.
- `addr_i = 2,3`: read 0; writes are ignored.

Receive FSM: IDLE → START → DATA → STOP → IDLE.
- **IDLE**: leave on the synchronized `rx` going 0. Load the bit counter with `DIV/2 - 1`.
- **START**: when the counter expires, resample the line.
  - If the line is 1, it was a glitch: return to IDLE, with no flag and no push.
  - Otherwise load the counter with `DIV - 1` and go to DATA.
- **DATA**: sample one bit per `DIV` clocks, 8 bits, LSB first, shifted into the shift register.
- **STOP**: sample once, then return to IDLE.
  - Stop bit = 1: push the byte.
  - Stop bit = 0: set frame error and discard the byte.

FIFO rules:
- Push while full: the byte is dropped and overrun is set. Existing contents are unchanged.
- Pop while empty: ignored.
- Push and pop in the same cycle: both take effect and the count is unchanged. When full, the pop frees the slot, so no overrun occurs.
- A flag clear and a flag set in the same cycle: the set wins.

Reset (asserted at any time, including mid-frame) immediately does all of the following:
- FSM to IDLE, counters to 0.
- FIFO emptied, both flags cleared.
- Synchronizer flops set to 1.
- `rx_valid_o` = 0, and `data_o` reads 0 at both registers.

## Timing
- `rx_i` passes through a 2-flop synchronizer, giving 2 cycles of latency before the FSM sees an edge.
- Sampling points are relative to the synchronized falling edge at cycle `E`:
  - Start check at `E + DIV/2`.
  - Data bit k at `E + DIV/2 + (k+1)·DIV`.
  - Stop bit at `E + DIV/2 + 9·DIV`.
- The push happens on the stop-sample clock edge. `rx_valid_o` and STATUS update on the following cycle.
- The FSM is back in IDLE on the cycle after the stop sample. A start bit arriving immediately after the nominal stop is detected without loss.
- Pop and clear take effect at the clock edge where `we_i` is high. DATA shows the next entry in the following cycle.
- `data_o` is purely combinational from `addr_i` and the registered state, with no read side effects.

## Structure
- Package `pkg_uart_rx` holds:
  - the `rx_state_t` enum (IDLE, START, DATA, STOP);
  - register offsets `UART_RX_STATUS = 2'd0` and `UART_RX_DATA = 2'd1`;
  - STATUS bit indices (VALID = 0, OVR = 1, FERR = 2, CNT_LSB = 4).
- Sub-module `module_uart_rx_fifo` is a synchronous FIFO parameterized by width and depth.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `dout`, `count`, `empty`, `full`.
  - Reset: same asynchronous active-low `rst_i`.
- The top level contains the synchronizer, the FSM with its bit counter and shift register, the flags, and the read mux.

## Test plan
Bench parameters are `CLK_HZ=1_000_000`, `BAUD=100_000`, giving `DIV=10`.
1. Send frame `0xA5` with stop = 1 → after the stop sample, `rx_valid_o=1` and STATUS reads `0x11`. DATA reads `0xA5`. Writing STATUS `0x1` → STATUS reads `0x00`.
2. Pulse `rx_i` low for 3 clocks → no push, no flag, and the FSM returns to IDLE. A following frame `0x3C` is received correctly.
3. Send frame `0x55` with stop = 0 → STATUS bit2 = 1 and count = 0. Writing STATUS `0x4` clears it.
4. Send 5 bytes `0x01`–`0x05` with no pops → count = 4 and overrun = 1. DATA pops in order read `0x01`–`0x04`.
5. With the FIFO full, time a pop to the same cycle as the 5th byte's stop sample → count stays 4 with no overrun. The 5th byte is last in order.
6. Assert `rst_i` low mid-way through the DATA state of a frame → all outputs read 0 and the FIFO is empty. After release, frame `0xC3` is received correctly.

Source files
------------

// File: rtl/module_uart_rx_periph_pkg.sv
// Purpose: shared types and register map for the UART receive peripheral.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkg_uart_rx;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam logic [1:0] UART_RX_STATUS = 2'd0;
    localparam logic [1:0] UART_RX_DATA   = 2'd1;

    localparam int ST_VALID   = 0;
    localparam int ST_OVR     = 1;
    localparam int ST_FERR    = 2;
    localparam int ST_CNT_LSB = 4;

    // STATUS read word: valid, overrun, frame error and a 3-bit FIFO count.
    function automatic logic [31:0] status_word(input logic valid, input logic ovr,
                                                input logic ferr, input logic [2:0] cnt);
        logic [31:0] w;
        w = '0;
        w[ST_VALID]            = valid;
        w[ST_OVR]              = ovr;
        w[ST_FERR]             = ferr;
        w[ST_CNT_LSB +: 3]     = cnt;
        return w;
    endfunction

endpackage

// File: rtl/module_uart_rx_fifo.sv
// Purpose: small synchronous FIFO holding received bytes.
// Latency: a push is visible at dout/count on the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
// Ports: clk_i/rst_i (async active-low), push/din in, pop in, dout/count/empty/full out.
// DEPTH must be a power of two and at least 2.
module module_uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: reads are gated by empty at the register mux.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/module_uart_rx_periph.sv
// Purpose: memory-mapped 8N1 UART receiver with a byte FIFO and STATUS/DATA registers.
// Latency: 2-cycle rx synchronizer; byte pushed on the stop-sample edge, visible the next cycle.
// Backpressure: none on the line; bytes arriving to a full FIFO are dropped and flag overrun.
// Ports: clk_i, rst_i (async active-low), we_i/addr_i/data_i bus write, rx_i serial in,
//        data_o combinational read data, rx_valid_o FIFO not empty.
module module_uart_rx_periph
    import pkg_uart_rx::*;
#(
    parameter int CLK_HZ     = 10_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] data_i,
    input  logic        rx_i,
    output logic [31:0] data_o,
    output logic        rx_valid_o
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2 - 1;
    localparam int CW   = $clog2(DIV);
    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            ovr;
    logic            ferr;

    logic            stop_tick;
    logic            push;
    logic            ferr_set;
    logic            ovr_set;
    logic            pop_req;
    logic [7:0]      fifo_dout;
    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic            unused_data;

    assign unused_data = ^data_i[31:3];

    // Synchronizer presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        cnt   <= CW'(HALF);
                        state <= START;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (rx_sync) begin
                        // Line back high at mid start bit: treat as noise.
                        state <= IDLE;
                    end else begin
                        cnt     <= CW'(DIV - 1);
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        shreg <= {rx_sync, shreg[7:1]};
                        cnt   <= CW'(DIV - 1);
                        if (bit_idx == 3'd7) state <= STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (cnt != '0) cnt <= cnt - CW'(1);
                    else           state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Push is decoded combinationally so the FIFO captures on the stop-sample edge itself.
    assign stop_tick = (state == STOP) && (cnt == '0);
    assign push      = stop_tick && rx_sync;
    assign ferr_set  = stop_tick && !rx_sync;
    assign pop_req   = we_i && (addr_i == UART_RX_STATUS) && data_i[0];
    assign ovr_set   = push && fifo_full && !pop_req;

    module_uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop_req),
        .din   (shreg),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)
                ovr <= 1'b1;
            else if (we_i && addr_i == UART_RX_STATUS && data_i[1])
                ovr <= 1'b0;
            if (ferr_set)
                ferr <= 1'b1;
            else if (we_i && addr_i == UART_RX_STATUS && data_i[2])
                ferr <= 1'b0;
        end
    end

    assign rx_valid_o = !fifo_empty;

    always_comb begin
        data_o = '0;
        case (addr_i)
            UART_RX_STATUS: data_o = status_word(!fifo_empty, ovr, ferr, 3'(fifo_count));
            UART_RX_DATA:   data_o = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
            default:        data_o = '0;
        endcase
    end

endmodule

// File: tb/tb_module_uart_rx_periph.sv
// Purpose: directed self-checking bench for the UART receive peripheral (DIV = 10).
// Latency: n/a.
// Backpressure: n/a.
module tb_module_uart_rx_periph;
    import pkg_uart_rx::*;

    logic        clk_i;
    logic        rst_i;
    logic        we_i;
    logic [1:0]  addr_i;
    logic [31:0] data_i;
    logic        rx_i;
    logic [31:0] data_o;
    logic        rx_valid_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       exp_ovr;
    logic       exp_ferr;

    module_uart_rx_periph #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .data_i     (data_i),
        .rx_i       (rx_i),
        .data_o     (data_o),
        .rx_valid_o (rx_valid_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        addr_i = a;
        #1;
        v = data_o;
    endtask

    task automatic wr_status(input logic [31:0] v);
        addr_i = UART_RX_STATUS;
        data_i = v;
        we_i   = 1'b1;
        @(posedge clk_i);
        #1;
        we_i   = 1'b0;
        data_i = '0;
    endtask

    // Compare STATUS and rx_valid_o against the scoreboard.
    task automatic check_status(input string tag);
        logic [31:0] e;
        logic [31:0] v;
        int n;
        n = q.size();
        e = '0;
        e[0]   = (n != 0);
        e[1]   = exp_ovr;
        e[2]   = exp_ferr;
        e[6:4] = n[2:0];
        rd(UART_RX_STATUS, v);
        chk({tag, "_status"}, v, e);
        chk({tag, "_valid"}, {31'd0, rx_valid_o}, {31'd0, e[0]});
    endtask

    // Read DATA, compare with the scoreboard head, then pop it.
    task automatic pop_check(input string tag);
        logic [31:0] v;
        logic [7:0]  h;
        h = (q.size() != 0) ? q[0] : 8'h00;
        rd(UART_RX_DATA, v);
        chk(tag, v, {24'd0, h});
        wr_status(32'h1);
        if (q.size() != 0) void'(q.pop_front());
    endtask

    // One 100-clock 8N1 frame starting right after a clock edge. Optionally times a
    // pop onto the stop-sample edge (clock 98 of the frame) or asserts reset at abort_at.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic pop_at_stop, input int abort_at);
        logic aborted;
        int idx;
        aborted = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (cyc == abort_at) begin
                rst_i   = 1'b0;
                rx_i    = 1'b1;
                aborted = 1'b1;
                break;
            end
            idx = cyc / 10;
            if (idx == 0)      rx_i = 1'b0;
            else if (idx == 9) rx_i = stop;
            else               rx_i = b[idx-1];
            if (pop_at_stop && cyc == 97) begin
                logic [31:0] v;
                rd(UART_RX_DATA, v);
                chk("pop_at_stop_head", v, {24'd0, q[0]});
                void'(q.pop_front());
                addr_i = UART_RX_STATUS;
                data_i = 32'h1;
                we_i   = 1'b1;
            end
            if (pop_at_stop && cyc == 98) begin
                we_i   = 1'b0;
                data_i = '0;
            end
            @(posedge clk_i);
            #1;
        end
        if (!aborted) begin
            rx_i = 1'b1;
            if (stop) begin
                if (q.size() < 4) q.push_back(b);
                else              exp_ovr = 1'b1;
            end else begin
                exp_ferr = 1'b1;
                repeat (20) @(posedge clk_i);
                #1;
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        rst_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        rx_i     = 1'b1;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        #1;
        check_status("reset");
        rd(UART_RX_DATA, v);
        chk("reset_data", v, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // 1: single good frame, then pop.
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        rd(UART_RX_STATUS, v);
        chk("t1_status_0x11", v, 32'h11);
        check_status("t1");
        pop_check("t1_data_a5");
        check_status("t1_after_pop");

        // 2: 3-clock glitch is ignored, next frame received.
        rx_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        check_status("t2_glitch");
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        check_status("t2_frame");
        pop_check("t2_data_3c");

        // 3: frame error, then clear it.
        send_frame(8'h55, 1'b0, 1'b0, -1);
        check_status("t3_ferr");
        wr_status(32'h4);
        exp_ferr = 1'b0;
        check_status("t3_cleared");

        // 4: five back-to-back bytes overflow a 4-deep FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, -1);
        check_status("t4_full_ovr");
        for (int i = 1; i <= 4; i++) pop_check($sformatf("t4_pop%0d", i));
        check_status("t4_empty");
        wr_status(32'h2);
        exp_ovr = 1'b0;
        check_status("t4_ovr_clear");

        // 5: pop coincides with the 5th byte's stop sample.
        for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0, -1);
        send_frame(8'h15, 1'b1, 1'b1, -1);
        check_status("t5_no_ovr");
        for (int i = 0; i < 4; i++) pop_check($sformatf("t5_pop%0d", i));
        check_status("t5_empty");

        // 6: reset in the middle of DATA with a byte already queued.
        send_frame(8'h77, 1'b1, 1'b0, -1);
        check_status("t6_pre");
        send_frame(8'hC3, 1'b1, 1'b0, 45);
        #1;
        q.delete();
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
        check_status("t6_in_reset");
        rd(UART_RX_DATA, v);
        chk("t6_reset_data", v, 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check_status("t6_released");
        send_frame(8'hC3, 1'b1, 1'b0, -1);
        check_status("t6_frame");
        pop_check("t6_data_c3");
        check_status("t6_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
